// File: rtl/seq_rca_addsub_pkg.sv
// Shared definitions for the sequential ripple-carry adder/subtractor:
// FSM state encoding and slice-count helpers.
package seq_rca_addsub_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic int unsigned calc_nchunk(input int unsigned width,
                                                input int unsigned chunk);
        return width / chunk;
    endfunction

    // A single-slice build still needs a 1-bit index register.
    function automatic int unsigned calc_idx_w(input int unsigned nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// 1-bit full adder cell.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple-carry adder built from full_adder cells.
// Also exposes the carry into the chunk MSB for signed-overflow detection.
module rca_chunk #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] s_o,
    output logic             cout_o,
    output logic             c_msb_in_o
);

    logic [CHUNK:0] c;

    assign c[0] = cin_i;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .a_i  (a_i[i]),
            .b_i  (b_i[i]),
            .ci_i (c[i]),
            .s_o  (s_o[i]),
            .co_o (c[i+1])
        );
    end

    assign cout_o     = c[CHUNK];
    assign c_msb_in_o = c[CHUNK-1];

endmodule

// File: rtl/seq_rca_addsub.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock, LSB first,
// with valid/ready handshakes on both sides and a signed-overflow flag.
module seq_rca_addsub
    import seq_rca_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    input  logic             c_in_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] s_o,
    output logic             c_out_o,
    output logic             ovf_o
);

    localparam int unsigned NChunk = calc_nchunk(WIDTH, CHUNK);
    localparam int unsigned IdxW   = calc_idx_w(NChunk);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NChunk - 1);

    state_e            state_q;
    logic [IdxW-1:0]   idx_q;
    logic              carry_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  s_q;
    logic              c_out_q;
    logic              ovf_q;
    logic              in_ready_q;
    logic              out_valid_q;

    int unsigned       base;
    logic [CHUNK-1:0]  slice_sum;
    logic              slice_cout;
    logic              slice_c_msb;

    always_comb begin
        base = 32'(idx_q) * CHUNK;
    end

    rca_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a_i        (a_q[base +: CHUNK]),
        .b_i        (b_q[base +: CHUNK]),
        .cin_i      (carry_q),
        .s_o        (slice_sum),
        .cout_o     (slice_cout),
        .c_msb_in_o (slice_c_msb)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        // Subtraction is a + ~b + 1, so B is inverted and carry forced at capture.
                        a_q        <= a_i;
                        b_q        <= b_i ^ {WIDTH{sub_i}};
                        carry_q    <= sub_i | c_in_i;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= StRun;
                    end
                end
                StRun: begin
                    s_q[base +: CHUNK] <= slice_sum;
                    carry_q            <= slice_cout;
                    idx_q              <= idx_q + 1'b1;
                    if (idx_q == LastIdx) begin
                        c_out_q     <= slice_cout;
                        ovf_q       <= slice_cout ^ slice_c_msb;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign s_o         = s_q;
    assign c_out_o     = c_out_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_seq_rca_addsub.sv
// Bench for seq_rca_addsub: directed cases, reset abort and random sweeps on a
// CHUNK=4 and a CHUNK=16 instance, checked against a scoreboard of model results.
module tb_seq_rca_addsub;

    localparam int unsigned W = 16;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a, b;
    logic         sub, c_in;
    logic         in_valid, out_ready;
    int           sel;

    logic         ir0, ov0, c0, v0, ir1, ov1, c1, v1;
    logic [W-1:0] s0, s1;
    logic         obs_ir, obs_ov, obs_c, obs_v;
    logic [W-1:0] obs_s;

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_rca_addsub #(.WIDTH(W), .CHUNK(4)) dut4 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid && (sel == 0)),
        .in_ready_o  (ir0),
        .a_i         (a),
        .b_i         (b),
        .sub_i       (sub),
        .c_in_i      (c_in),
        .out_valid_o (ov0),
        .out_ready_i (out_ready && (sel == 0)),
        .s_o         (s0),
        .c_out_o     (c0),
        .ovf_o       (v0)
    );

    seq_rca_addsub #(.WIDTH(W), .CHUNK(16)) dut16 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid && (sel == 1)),
        .in_ready_o  (ir1),
        .a_i         (a),
        .b_i         (b),
        .sub_i       (sub),
        .c_in_i      (c_in),
        .out_valid_o (ov1),
        .out_ready_i (out_ready && (sel == 1)),
        .s_o         (s1),
        .c_out_o     (c1),
        .ovf_o       (v1)
    );

    assign obs_ir = (sel == 0) ? ir0 : ir1;
    assign obs_ov = (sel == 0) ? ov0 : ov1;
    assign obs_s  = (sel == 0) ? s0  : s1;
    assign obs_c  = (sel == 0) ? c0  : c1;
    assign obs_v  = (sel == 0) ? v0  : v1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic msub, input logic mcin);
        res_t         r;
        logic [W-1:0] bb;
        logic         ci;
        logic [W:0]   f;
        bb  = msub ? ~mb : mb;
        ci  = msub ? 1'b1 : mcin;
        f   = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, ci};
        r.s = f[W-1:0];
        r.c = f[W];
        r.v = (ma[W-1] == bb[W-1]) && (f[W-1] != ma[W-1]);
        return r;
    endfunction

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tsub,
                         input logic tcin, input int bp,
                         output logic [W-1:0] rs, output logic rc, output logic rv);
        int   n;
        res_t e;
        n  = (sel == 0) ? 4 : 1;
        rs = '0;
        rc = 1'b0;
        rv = 1'b0;
        @(negedge clk);
        a = ta; b = tb; sub = tsub; c_in = tcin; in_valid = 1'b1; out_ready = 1'b0;
        chk("idle_in_ready", 32'(obs_ir), 32'd1);
        @(posedge clk);
        exp_q.push_back(model(ta, tb, tsub, tcin));
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom); c_in = 1'($urandom);
        chk("run_in_ready", 32'(obs_ir), 32'd0);
        chk("run_out_valid", 32'(obs_ov), 32'd0);
        for (int k = 1; k < n; k++) begin
            @(negedge clk);
            chk("run_in_ready", 32'(obs_ir), 32'd0);
            chk("run_out_valid", 32'(obs_ov), 32'd0);
        end
        @(negedge clk);
        chk("latency_out_valid", 32'(obs_ov), 32'd1);
        for (int t = 0; t < 20 && !obs_ov; t++) @(negedge clk);
        if (!obs_ov) begin
            chk("timeout_out_valid", 32'(obs_ov), 32'd1);
            exp_q.delete();
            return;
        end
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'(exp_q.size()), 32'd1);
            return;
        end
        e = exp_q[0];
        for (int k = 0; k < bp; k++) begin
            in_valid = 1'b1;
            a = W'($urandom); b = W'($urandom); sub = 1'($urandom); c_in = 1'($urandom);
            @(negedge clk);
            chk("bp_out_valid", 32'(obs_ov), 32'd1);
            chk("bp_in_ready", 32'(obs_ir), 32'd0);
            chk("bp_s", 32'(obs_s), 32'(e.s));
            chk("bp_c_out", 32'(obs_c), 32'(e.c));
            chk("bp_ovf", 32'(obs_v), 32'(e.v));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        e = exp_q.pop_front();
        chk("res_s", 32'(obs_s), 32'(e.s));
        chk("res_c_out", 32'(obs_c), 32'(e.c));
        chk("res_ovf", 32'(obs_v), 32'(e.v));
        rs = obs_s;
        rc = obs_c;
        rv = obs_v;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_in_ready", 32'(obs_ir), 32'd1);
        chk("post_out_valid", 32'(obs_ov), 32'd0);
    endtask

    initial begin
        logic [W-1:0] rs;
        logic         rc, rv;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0; c_in = 1'b0; sel = 0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sel = d;
            #1;
            chk("rst_in_ready", 32'(obs_ir), 32'd1);
            chk("rst_out_valid", 32'(obs_ov), 32'd0);
            chk("rst_s", 32'(obs_s), 32'd0);
            chk("rst_c_out", 32'(obs_c), 32'd0);
            chk("rst_ovf", 32'(obs_v), 32'd0);
        end
        sel = 0;
        @(negedge clk);
        rst_n = 1'b1;

        do_op(16'h00FF, 16'h0F01, 1'b0, 1'b0, 0, rs, rc, rv);
        chk("add1_s", 32'(rs), 32'h1000);
        chk("add1_c", 32'(rc), 32'd0);
        chk("add1_v", 32'(rv), 32'd0);

        do_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 0, rs, rc, rv);
        chk("add2_s", 32'(rs), 32'hFFFF);
        chk("add2_c", 32'(rc), 32'd1);
        chk("add2_v", 32'(rv), 32'd0);

        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, rs, rc, rv);
        chk("add3_s", 32'(rs), 32'h8000);
        chk("add3_c", 32'(rc), 32'd0);
        chk("add3_v", 32'(rv), 32'd1);

        do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, rs, rc, rv);
        chk("sub1_s", 32'(rs), 32'hFFFE);
        chk("sub1_c", 32'(rc), 32'd0);
        chk("sub1_v", 32'(rv), 32'd0);

        do_op(16'h8000, 16'h0001, 1'b1, 1'b1, 3, rs, rc, rv);
        chk("sub2_s", 32'(rs), 32'h7FFF);
        chk("sub2_c", 32'(rc), 32'd1);
        chk("sub2_v", 32'(rv), 32'd1);

        // Abort an operation after its second RUN edge; c_out/ovf are 1 from the last op.
        @(negedge clk);
        a = 16'hABCD; b = 16'h1111; sub = 1'b0; c_in = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("abort_in_ready", 32'(obs_ir), 32'd1);
        chk("abort_out_valid", 32'(obs_ov), 32'd0);
        chk("abort_s", 32'(obs_s), 32'd0);
        chk("abort_c_out", 32'(obs_c), 32'd0);
        chk("abort_ovf", 32'(obs_v), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(16'h1234, 16'h1111, 1'b0, 1'b0, 0, rs, rc, rv);
        chk("after_abort_s", 32'(rs), 32'h2345);

        for (int i = 0; i < 1000; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)), rs, rc, rv);
        end

        sel = 1;
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1, rs, rc, rv);
        chk("c16_add_s", 32'(rs), 32'h8000);
        chk("c16_add_v", 32'(rv), 32'd1);
        do_op(16'h8000, 16'h0001, 1'b1, 1'b0, 0, rs, rc, rv);
        chk("c16_sub_s", 32'(rs), 32'h7FFF);
        chk("c16_sub_c", 32'(rc), 32'd1);
        for (int i = 0; i < 200; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)), rs, rc, rv);
        end

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_rca_addsub.md
Name: seq_rca_addsub

Overview:
- Parametrised, multi-cycle ripple-carry adder/subtractor.
- Each cycle it adds one CHUNK-bit slice, LSB slice first, through a combinational ripple chunk; the inter-slice carry is held in a register.
- Adds valid/ready handshakes, a subtract mode and a signed-overflow flag, none of which the fixed 5-bit combinational adder has.
- Serves as the arithmetic unit for datapaths where area matters more than latency.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle; NCHUNK = WIDTH/CHUNK, and NCHUNK >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  0: a+b+c_in; 1: a-b (c_in ignored)
- c_in  input  1  carry-in for add mode
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- s  output  WIDTH  sum/difference
- c_out  output  1  carry out of MSB; in sub mode 1 = no borrow
- ovf  output  1  two's-complement overflow

Behaviour:
- One clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, s=0, c_out=0, ovf=0; all internal registers cleared.
- FSM states and transitions:
  - IDLE: in_ready=1. When in_valid=1, the edge captures a, b^{WIDTH{sub}}, carry=sub?1:c_in, clears chunk index, goes to RUN.
  - RUN: in_ready=0, out_valid=0. Each edge adds slice [idx*CHUNK +: CHUNK] with the carry register, writes that slice of s, updates carry, increments idx. After the edge that processes slice NCHUNK-1, go to DONE.
  - DONE: out_valid=1; s, c_out, ovf held stable. When out_ready=1, the edge goes to IDLE and out_valid falls.
- Latency: out_valid is high NCHUNK edges after the accepting edge; no same-cycle bypass.
- Throughput: one operation per NCHUNK+2 cycles minimum.
- in_valid is ignored outside IDLE. Operand inputs may change freely after acceptance.
- c_out = carry out of bit WIDTH-1.
- ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1. It comes from the final slice; the carry into the MSB is taken from within the chunk.
- s is fully updated only in DONE; intermediate slices may be visible during RUN. Consumers sample only when out_valid=1.
- Modular arithmetic: results wrap at 2^WIDTH, no saturation.
- Reset asserted mid-RUN or in DONE aborts the operation immediately: outputs return to reset values and the result is lost.
- Any sub value is legal; mode is latched at acceptance.
- With CHUNK=WIDTH, NCHUNK=1: RUN lasts exactly one cycle.

Decomposition:
- Shared package holds: the FSM state encoding (IDLE, RUN, DONE) as a typedef, and the NCHUNK/index-width helper constant functions.
- One sub-module: rca_chunk, a purely combinational CHUNK-bit ripple adder built from the existing 1-bit full adder cell.
  - Ports: a, b, cin, s, cout, and c_msb_in (carry into the chunk MSB, used for ovf).
  - Generate loop over CHUNK.

Test Plan (WIDTH=16, CHUNK=4):
- Add 0x00FF+0x0F01, c_in=0 -> s=0x1000, c_out=0, ovf=0. out_valid rises exactly 4 edges after accept; in_ready low throughout.
- Add 0xFFFF+0xFFFF, c_in=1 -> s=0xFFFF, c_out=1, ovf=0. Add 0x7FFF+0x0001 -> s=0x8000, c_out=0, ovf=1.
- Sub 0x0005-0x0007 -> s=0xFFFE, c_out=0, ovf=0. Sub 0x8000-0x0001 -> s=0x7FFF, c_out=1, ovf=1. c_in=1 is applied in sub mode and must have no effect.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid and operands.
  - Required: s/c_out/ovf stable, out_valid=1, in_ready=0, no new accept.
  - On out_ready=1: IDLE the next cycle, then a fresh operation is accepted.
- Reset: pulse rst_n low after the 2nd RUN edge.
  - Required: outputs zero immediately (asynchronous), state IDLE.
  - A subsequent 0x1234+0x1111 yields 0x2345.
- Randomised sweep of 1000 operations with random sub/c_in/backpressure, plus a CHUNK=16 build, each compared against a reference model.
